// File: rtl/kanagawa_show_ahead_fifo_pkg.sv
// ============================================================================
// Module   : kanagawa_show_ahead_fifo_pkg
// Brief    : Sizing, threshold and packed-slice helpers for the show-ahead FIFOs
// Revision : 1.0
// ============================================================================
`default_nettype none

package kanagawa_show_ahead_fifo_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int chan_width(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

  function automatic int almost_full_val(input int depth, input int entries);
    return depth - entries;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kanagawa_show_ahead_fifo_channel.sv
// ============================================================================
// Module   : kanagawa_show_ahead_fifo_channel
// Brief    : One show-ahead register FIFO; storage style chosen by MUX_ON_READ
// Revision : 1.0
// ============================================================================
`default_nettype none

module kanagawa_show_ahead_fifo_channel
  import kanagawa_show_ahead_fifo_pkg::*;
#(
  parameter int DEPTH              = 7,
  parameter int LOG_DEPTH          = $clog2(DEPTH),
  parameter int WIDTH              = 32,
  parameter int ALMOSTFULL_ENTRIES = 2,
  parameter int ALMOSTEMPTY_VAL    = 3,
  parameter int MUX_ON_READ        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_accept,
  input  logic [WIDTH-1:0]     data,
  input  logic                 rdreq,
  output logic                 full,
  output logic                 almost_full,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [LOG_DEPTH:0]   usedw,
  output logic [WIDTH-1:0]     q
);

  localparam int CW       = LOG_DEPTH + 1;
  localparam int C_AF_VAL = almost_full_val(DEPTH, ALMOSTFULL_ENTRIES);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_full;
  logic          r_almost_full;
  logic          r_empty;
  logic          r_almost_empty;
  logic          w_rd_accept;

  // An empty channel never pops, even if a write lands in the same cycle.
  assign w_rd_accept = rdreq && !r_empty;

  always_comb begin
    w_count_next = r_count;
    if (wr_accept && !w_rd_accept) begin
      w_count_next = r_count + CW'(1);
    end else if (!wr_accept && w_rd_accept) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count        <= '0;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      r_count        <= w_count_next;
      r_full         <= (int'(w_count_next) == DEPTH);
      r_almost_full  <= (int'(w_count_next) >= C_AF_VAL);
      r_empty        <= (w_count_next == '0);
      r_almost_empty <= (int'(w_count_next) <= ALMOSTEMPTY_VAL);
    end
  end

  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign usedw        = r_count;

  generate
    if (MUX_ON_READ != 0) begin : g_mux_on_read
      logic [WIDTH-1:0]     r_mem [DEPTH];
      logic [LOG_DEPTH-1:0] r_wr_ptr;
      logic [LOG_DEPTH-1:0] r_rd_ptr;

      // Pointers wrap explicitly so non-power-of-two depths work.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else begin
          if (wr_accept) begin
            r_wr_ptr <= (r_wr_ptr == LOG_DEPTH'(DEPTH - 1)) ? '0 : r_wr_ptr + LOG_DEPTH'(1);
          end
          if (w_rd_accept) begin
            r_rd_ptr <= (r_rd_ptr == LOG_DEPTH'(DEPTH - 1)) ? '0 : r_rd_ptr + LOG_DEPTH'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (wr_accept) begin
          r_mem[r_wr_ptr] <= data;
        end
      end

      assign q = r_mem[r_rd_ptr];
    end else begin : g_shift_to_head
      logic [WIDTH-1:0]     r_mem [DEPTH];
      logic [LOG_DEPTH-1:0] w_wr_idx;

      // Entry 0 is always the head; a simultaneous pop moves the tail slot down.
      assign w_wr_idx = LOG_DEPTH'(r_count - CW'(w_rd_accept));

      always_ff @(posedge clk) begin
        if (w_rd_accept) begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            r_mem[i] <= r_mem[i+1];
          end
        end
        if (wr_accept) begin
          r_mem[w_wr_idx] <= data;
        end
      end

      assign q = r_mem[0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/kanagawa_show_ahead_multi_channel_fifo.sv
// ============================================================================
// Module   : kanagawa_show_ahead_multi_channel_fifo
// Brief    : NUM_CHANNELS show-ahead FIFOs behind one steered write port.
//            KANAGAWA_FIFO_ERROR_FLAGS_EN enables sticky overflow/underflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module kanagawa_show_ahead_multi_channel_fifo
  import kanagawa_show_ahead_fifo_pkg::*;
#(
  parameter int NUM_CHANNELS       = 4,
  parameter int DEPTH              = 7,
  parameter int LOG_DEPTH          = $clog2(DEPTH),
  parameter int WIDTH              = 32,
  parameter int ALMOSTFULL_ENTRIES = 2,
  parameter int ALMOSTEMPTY_VAL    = 3,
  parameter int MUX_ON_READ        = 1,
  parameter int CHAN_W             = chan_width(NUM_CHANNELS)
) (
  input  logic                                  clock,
  input  logic                                  rst,
  input  logic                                  wrreq,
  input  logic [CHAN_W-1:0]                     wr_chan,
  input  logic [WIDTH-1:0]                      data,
  input  logic [NUM_CHANNELS-1:0]               rdreq,
  output logic [NUM_CHANNELS-1:0]               full,
  output logic [NUM_CHANNELS-1:0]               almost_full,
  output logic [NUM_CHANNELS*(LOG_DEPTH+1)-1:0] usedw,
  output logic [NUM_CHANNELS-1:0]               empty,
  output logic [NUM_CHANNELS-1:0]               almost_empty,
  output logic [NUM_CHANNELS*WIDTH-1:0]         q,
  output logic [NUM_CHANNELS-1:0]               overflow,
  output logic [NUM_CHANNELS-1:0]               underflow
);

  localparam int UW = LOG_DEPTH + 1;

  logic                    r_rst_delayed;
  logic                    w_guard;
  logic [NUM_CHANNELS-1:0] w_sel;
  logic [NUM_CHANNELS-1:0] w_wr_accept;
  logic [NUM_CHANNELS-1:0] w_full_ch;
  logic [NUM_CHANNELS-1:0] w_af_ch;

  always_ff @(posedge clock) begin
    r_rst_delayed <= rst;
  end

  // Producers see every channel as full until the FIFOs have settled.
  assign w_guard     = rst || r_rst_delayed;
  assign full        = w_full_ch | {NUM_CHANNELS{w_guard}};
  assign almost_full = w_af_ch   | {NUM_CHANNELS{w_guard}};
  assign w_wr_accept = w_sel & ~full;

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      // Out-of-range channel indices match nothing and are dropped.
      assign w_sel[c] = wrreq && (int'(wr_chan) == c);

      kanagawa_show_ahead_fifo_channel #(
        .DEPTH              (DEPTH),
        .LOG_DEPTH          (LOG_DEPTH),
        .WIDTH              (WIDTH),
        .ALMOSTFULL_ENTRIES (ALMOSTFULL_ENTRIES),
        .ALMOSTEMPTY_VAL    (ALMOSTEMPTY_VAL),
        .MUX_ON_READ        (MUX_ON_READ)
      ) u_chan (
        .clk          (clock),
        .rst          (rst),
        .wr_accept    (w_wr_accept[c]),
        .data         (data),
        .rdreq        (rdreq[c]),
        .full         (w_full_ch[c]),
        .almost_full  (w_af_ch[c]),
        .empty        (empty[c]),
        .almost_empty (almost_empty[c]),
        .usedw        (usedw[slice_lo(c, UW) +: UW]),
        .q            (q[slice_lo(c, WIDTH) +: WIDTH])
      );
    end
  endgenerate

`ifdef KANAGAWA_FIFO_ERROR_FLAGS_EN
  logic [NUM_CHANNELS-1:0] r_overflow;
  logic [NUM_CHANNELS-1:0] r_underflow;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_overflow  <= '0;
      r_underflow <= '0;
    end else begin
      r_overflow  <= r_overflow  | (w_sel & full);
      r_underflow <= r_underflow | (rdreq & empty);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (w_sel[c] && full[c])   $error("overflow on channel %0d", c);
        if (rdreq[c] && empty[c]) $error("underflow on channel %0d", c);
      end
    end
  end
`endif

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = '0;
  assign underflow = '0;
`endif

endmodule

`default_nettype wire
